// File: rtl/apple_1_pia_uart_pkg.sv
// Shared constants, FSM state types and the keyboard character filter
// for the Apple-1 PIA <-> UART bridge.
package apple_1_pia_uart_pkg;

  localparam logic [6:0] ASCII_CR          = 7'h0D;
  localparam logic [6:0] ASCII_LF          = 7'h0A;
  localparam logic [6:0] ASCII_LOWER_A     = 7'h61;
  localparam logic [6:0] ASCII_LOWER_Z     = 7'h7A;
  localparam logic [6:0] ASCII_CASE_OFFSET = 7'h20;

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [1:0] {K_IDLE, K_RDY, K_WAIT}           kbd_state_t;
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_t;

  // WozMon only understands upper case; bit 7 must already be clear.
  function automatic logic [7:0] to_upper(input logic [7:0] c);
    logic [7:0] r;
    r = c;
    if (c >= {1'b0, ASCII_LOWER_A} && c <= {1'b0, ASCII_LOWER_Z})
      r = c - {1'b0, ASCII_CASE_OFFSET};
    return r;
  endfunction

endpackage

// File: rtl/apple_1_pia_uart_bridge_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, start-edge detect, mid-bit sampling.
// Emits each byte with a good stop bit as a one-cycle rx_valid strobe.
module apple_1_uart_rx
  import apple_1_pia_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1042
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rxd,
  output logic [7:0] rx_byte,
  output logic       rx_valid
);

  localparam int unsigned       CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]       sync;
  logic             rx_prev;
  logic             rx_s;
  logic             rx_fall;
  rx_state_t        rx_state,   rx_state_n;
  logic [CNT_W-1:0] cnt,        cnt_n;
  logic [2:0]       bit_idx,    bit_idx_n;
  logic [7:0]       shift,      shift_n;
  logic [7:0]       rx_byte_n;
  logic             rx_valid_n;

  assign rx_s    = sync[1];
  assign rx_fall = rx_prev & ~rx_s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync     <= '1;
      rx_prev  <= 1'b1;
      rx_state <= R_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
    end else begin
      sync     <= {sync[0], uart_rxd};
      rx_prev  <= rx_s;
      rx_state <= rx_state_n;
      cnt      <= cnt_n;
      bit_idx  <= bit_idx_n;
      shift    <= shift_n;
      rx_byte  <= rx_byte_n;
      rx_valid <= rx_valid_n;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    cnt_n      = cnt;
    bit_idx_n  = bit_idx;
    shift_n    = shift;
    rx_byte_n  = rx_byte;
    rx_valid_n = 1'b0;
    unique case (rx_state)
      R_IDLE: begin
        if (rx_fall) begin
          rx_state_n = R_START;
          cnt_n      = '0;
        end
      end
      R_START: begin
        if (cnt == HALF_LAST) begin
          cnt_n      = '0;
          bit_idx_n  = '0;
          rx_state_n = rx_s ? R_IDLE : R_DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      R_DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n     = '0;
          shift_n   = {rx_s, shift[7:1]};
          bit_idx_n = bit_idx + 1'b1;
          if (bit_idx == 3'd7) rx_state_n = R_STOP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      R_STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n      = '0;
          rx_state_n = R_IDLE;
          if (rx_s) begin
            rx_byte_n  = shift;
            rx_valid_n = 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: rx_state_n = R_IDLE;
    endcase
  end

endmodule

// File: rtl/apple_1_pia_uart_bridge.sv
// Apple-1 serial terminal front end: UART RX -> filter -> FIFO -> PIA keyboard
// handshake, and PIA display handshake -> UART TX with CR->CR+LF expansion.
module apple_1_pia_uart_bridge
  import apple_1_pia_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1042,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rxd,
  output logic       uart_txd,
  output logic       kbd_rdy,
  output logic [6:0] kbd_data,
  input  logic       kbd_ack,
  input  logic       dsp_rdy,
  input  logic [6:0] dsp_data,
  output logic       dsp_ack,
  output logic       rx_overrun
);

  localparam int unsigned      PTR_W    = $clog2(FIFO_DEPTH);
  localparam int unsigned      CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [7:0] rx_byte;
  logic       rx_valid;

  apple_1_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk      (clk),
    .reset    (reset),
    .uart_rxd (uart_rxd),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid)
  );

  // ---------------- receive filter and FIFO ----------------
  logic [7:0]       rx_char;
  logic             push_req, push, pop;
  logic             fifo_empty, fifo_full;
  logic [6:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   fifo_count;

  assign rx_char    = to_upper(rx_byte & 8'h7F);
  assign push_req   = rx_valid && (rx_char != {1'b0, ASCII_LF});
  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == (PTR_W+1)'(FIFO_DEPTH));
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push       = push_req && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= rx_char[6:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      rx_overrun <= 1'b0;
    end else begin
      rx_overrun <= push_req && !push;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // ---------------- keyboard handshake ----------------
  kbd_state_t kbd_state, kbd_state_n;
  logic       kbd_load;

  assign kbd_rdy = (kbd_state == K_RDY);
  assign pop     = (kbd_state == K_RDY) && kbd_ack;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      kbd_state <= K_IDLE;
      kbd_data  <= '0;
    end else begin
      kbd_state <= kbd_state_n;
      if (kbd_load) kbd_data <= fifo_mem[rd_ptr];
    end
  end

  always_comb begin
    kbd_state_n = kbd_state;
    kbd_load    = 1'b0;
    case (kbd_state)
      K_IDLE: if (!fifo_empty) begin
        kbd_load    = 1'b1;
        kbd_state_n = K_RDY;
      end
      K_RDY:  if (kbd_ack)  kbd_state_n = K_WAIT;
      K_WAIT: if (!kbd_ack) kbd_state_n = K_IDLE;
      default: kbd_state_n = K_IDLE;
    endcase
  end

  // ---------------- display capture and transmitter ----------------
  tx_state_t        tx_state, tx_state_n;
  logic [CNT_W-1:0] tx_cnt,   tx_cnt_n;
  logic [2:0]       tx_bit,   tx_bit_n;
  logic [7:0]       tx_shift, tx_shift_n;
  logic             txd_r,    txd_n;
  logic             lf_pend,  lf_pend_n;
  logic             ack_r,    ack_n;
  logic             tick;

  assign uart_txd = txd_r;
  assign dsp_ack  = ack_r;
  assign tick     = (tx_cnt == BIT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state <= T_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      txd_r    <= 1'b1;
      lf_pend  <= 1'b0;
      ack_r    <= 1'b0;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      txd_r    <= txd_n;
      lf_pend  <= lf_pend_n;
      ack_r    <= ack_n;
    end
  end

  // tx_shift always holds the not-yet-sent bits, LSB next on the line.
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt + 1'b1;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    txd_n      = txd_r;
    lf_pend_n  = lf_pend;
    ack_n      = ack_r && dsp_rdy;
    unique case (tx_state)
      T_IDLE: begin
        txd_n    = 1'b1;
        tx_cnt_n = '0;
        if (!lf_pend && !ack_r && dsp_rdy) begin
          tx_shift_n = {1'b0, dsp_data};
          lf_pend_n  = (dsp_data == ASCII_CR);
          ack_n      = 1'b1;
          txd_n      = 1'b0;
          tx_state_n = T_START;
        end
      end
      T_START: begin
        if (tick) begin
          tx_cnt_n   = '0;
          tx_bit_n   = '0;
          txd_n      = tx_shift[0];
          tx_shift_n = {1'b0, tx_shift[7:1]};
          tx_state_n = T_DATA;
        end
      end
      T_DATA: begin
        if (tick) begin
          tx_cnt_n = '0;
          if (tx_bit == 3'd7) begin
            txd_n      = 1'b1;
            tx_state_n = T_STOP;
          end else begin
            txd_n      = tx_shift[0];
            tx_shift_n = {1'b0, tx_shift[7:1]};
            tx_bit_n   = tx_bit + 1'b1;
          end
        end
      end
      T_STOP: begin
        if (tick) begin
          tx_cnt_n = '0;
          if (lf_pend) begin
            tx_shift_n = {1'b0, ASCII_LF};
            lf_pend_n  = 1'b0;
            txd_n      = 1'b0;
            tx_state_n = T_START;
          end else begin
            tx_state_n = T_IDLE;
          end
        end
      end
      default: tx_state_n = T_IDLE;
    endcase
  end

endmodule

// File: tb/tb_apple_1_pia_uart_bridge.sv
// Self-checking bench for apple_1_pia_uart_bridge: directed scenarios plus
// randomized traffic checked against a queue-based terminal model.
module tb_apple_1_pia_uart_bridge;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       uart_rxd = 1'b1;
  logic       kbd_ack = 1'b0;
  logic       dsp_rdy = 1'b0;
  logic [6:0] dsp_data = '0;
  logic       uart_txd, kbd_rdy, dsp_ack, rx_overrun;
  logic [6:0] kbd_data;

  int total = 0, bad = 0;
  int cyc = 0, ovr_seen = 0, ovr_model = 0;
  int kq[$];

  apple_1_pia_uart_bridge #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .uart_rxd   (uart_rxd),
    .uart_txd   (uart_txd),
    .kbd_rdy    (kbd_rdy),
    .kbd_data   (kbd_data),
    .kbd_ack    (kbd_ack),
    .dsp_rdy    (dsp_rdy),
    .dsp_data   (dsp_data),
    .dsp_ack    (dsp_ack),
    .rx_overrun (rx_overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (reset && rx_overrun) ovr_seen++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Terminal model: what the Apple-1 should see for a received byte, -1 = nothing.
  function automatic int kbd_code(input logic [7:0] b);
    int c;
    c = int'(b) % 128;
    if (c == 10) return -1;
    if (c >= 97 && c <= 122) return c - 32;
    return c;
  endfunction

  task automatic wait_until(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic uart_send(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      uart_rxd = fr[i];
      repeat (CPB - 1) @(negedge clk);
    end
    @(negedge clk);
    uart_rxd = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic expect_kbd(input string tag);
    if (kq.size() > 0) begin
      chk({tag, "_rdy"}, kbd_rdy, 1);
      chk({tag, "_data"}, kbd_data, kq[0]);
    end else begin
      chk({tag, "_idle"}, kbd_rdy, 0);
    end
  endtask

  task automatic model_send(input string tag, input logic [7:0] b, input logic stop);
    int c;
    uart_send(b, stop);
    c = kbd_code(b);
    if (stop && c >= 0) begin
      if (kq.size() < DEPTH) kq.push_back(c);
      else ovr_model++;
    end
    chk({tag, "_overruns"}, ovr_seen, ovr_model);
    expect_kbd(tag);
  endtask

  task automatic do_ack(input string tag, input int hold);
    @(negedge clk);
    kbd_ack = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_rdy_during_ack"}, kbd_rdy, 0);
    end
    kbd_ack = 1'b0;
    if (kq.size() > 0) void'(kq.pop_front());
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_ack(output int at_cyc);
    int n;
    n = 0;
    while (dsp_ack !== 1'b1 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("dsp_ack_wait", dsp_ack, 1);
    at_cyc = cyc;
  endtask

  // s = cycle count sampled just after the edge that started the frame.
  task automatic check_frame(input string tag, input logic [7:0] b, input int s);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      wait_until(s + CPB * k + CPB / 2);
      chk($sformatf("%s_bit%0d", tag, k), uart_txd, fr[k]);
    end
  endtask

  task automatic dsp_send(input string tag, input logic [6:0] c);
    int s;
    @(negedge clk);
    dsp_data = c;
    dsp_rdy  = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_ack"}, dsp_ack, 1);
    chk({tag, "_start"}, uart_txd, 0);
    s = cyc;
    @(negedge clk);
    dsp_rdy = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, "_ack_drop"}, dsp_ack, 0);
    check_frame(tag, {1'b0, c}, s);
    if (c == 7'h0D) begin
      check_frame({tag, "_lf"}, 8'h0A, s + 10 * CPB);
      wait_until(s + 20 * CPB + 2);
    end else begin
      wait_until(s + 10 * CPB + 2);
    end
    chk({tag, "_idle"}, uart_txd, 1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int s, t;
    logic [7:0] b;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_txd", uart_txd, 1);
    chk("rst_kbd_rdy", kbd_rdy, 0);
    chk("rst_kbd_data", kbd_data, 0);
    chk("rst_dsp_ack", dsp_ack, 0);
    chk("rst_overrun", rx_overrun, 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Lowercase 'a' delivered as 'A'
    model_send("rx_a", 8'h61, 1'b1);
    do_ack("rx_a", 3);
    expect_kbd("rx_a_after");

    // Overrun: fifth byte dropped, first four delivered in order
    for (int i = 0; i < 5; i++) model_send($sformatf("ovr%0d", i), 8'(8'h31 + i), 1'b1);
    chk("ovr_once", ovr_seen, 1);
    for (int i = 0; i < 4; i++) begin
      expect_kbd($sformatf("ovr_deliver%0d", i));
      do_ack("ovr", 2);
    end
    expect_kbd("ovr_drained");
    model_send("lf", 8'h0A, 1'b1);
    model_send("lf_hi", 8'h8A, 1'b1);

    // Framing error and false start
    model_send("frame_err", 8'h41, 1'b0);
    @(negedge clk);
    uart_rxd = 1'b0;
    repeat (8) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_no_rdy", kbd_rdy, 0);
    model_send("after_glitch", 8'h62, 1'b1);
    do_ack("after_glitch", 1);

    // Display 'R' and a held dsp_rdy
    dsp_send("dsp_R", 7'h52);
    @(negedge clk);
    dsp_data = 7'h2A;
    dsp_rdy  = 1'b1;
    @(posedge clk);
    #1;
    chk("held_ack", dsp_ack, 1);
    s = cyc;
    check_frame("held", 8'h2A, s);
    wait_until(s + 10 * CPB + 20);
    chk("held_no_recapture_ack", dsp_ack, 1);
    chk("held_no_recapture_txd", uart_txd, 1);
    @(negedge clk);
    dsp_rdy = 1'b0;
    @(posedge clk);
    #1;
    chk("held_ack_drop", dsp_ack, 0);

    // CR expansion with a second request arriving mid-sequence
    @(negedge clk);
    dsp_data = 7'h0D;
    dsp_rdy  = 1'b1;
    @(posedge clk);
    #1;
    chk("cr_ack", dsp_ack, 1);
    s = cyc;
    @(negedge clk);
    dsp_rdy = 1'b0;
    fork
      begin
        check_frame("cr", 8'h0D, s);
        check_frame("cr_lf", 8'h0A, s + 10 * CPB);
      end
      begin
        repeat (4) @(negedge clk);
        dsp_data = 7'h41;
        dsp_rdy  = 1'b1;
        wait_ack(t);
        chk("cr_second_ack_cycle", t, s + 20 * CPB + 1);
        @(negedge clk);
        dsp_rdy = 1'b0;
        check_frame("cr_second", 8'h41, t);
        wait_until(t + 10 * CPB + 2);
      end
    join

    // Reset in the middle of RX and TX frames
    model_send("pre_rst1", 8'h31, 1'b1);
    model_send("pre_rst2", 8'h32, 1'b1);
    fork
      uart_send(8'h55, 1'b1);
      begin
        @(negedge clk);
        dsp_data = 7'h52;
        dsp_rdy  = 1'b1;
        repeat (70) @(negedge clk);
        chk("pre_rst_txd_low", uart_txd, 0);
        #2;
        reset   = 1'b0;
        dsp_rdy = 1'b0;
        #1;
        chk("midrst_txd", uart_txd, 1);
        chk("midrst_kbd_rdy", kbd_rdy, 0);
        chk("midrst_dsp_ack", dsp_ack, 0);
      end
    join
    kq.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    chk("postrst_fifo_empty", kbd_rdy, 0);
    chk("postrst_txd", uart_txd, 1);
    model_send("postrst_z", 8'h7A, 1'b1);
    do_ack("postrst_z", 1);

    // Randomized receive traffic against the model
    for (int it = 0; it < 24; it++) begin
      if (kq.size() > 0 && $urandom_range(0, 2) == 0) begin
        expect_kbd($sformatf("rnd%0d_pre", it));
        do_ack($sformatf("rnd%0d", it), $urandom_range(1, 3));
      end else begin
        case ($urandom_range(0, 7))
          0:       b = 8'h0A;
          1, 2:    b = 8'(8'h61 + $urandom_range(0, 25));
          3:       b = 8'(8'hE1 + $urandom_range(0, 25));
          default: b = 8'($urandom_range(0, 255));
        endcase
        model_send($sformatf("rnd%0d", it), b, 1'b1);
      end
    end
    while (kq.size() > 0) begin
      expect_kbd("drain");
      do_ack("drain", 1);
    end
    expect_kbd("drain_done");

    // Randomized display characters
    for (int it = 0; it < 5; it++) begin
      if ($urandom_range(0, 3) == 0) dsp_send($sformatf("rdsp%0d", it), 7'h0D);
      else dsp_send($sformatf("rdsp%0d", it), 7'($urandom_range(0, 127)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apple_1_pia_uart_bridge.md
# apple_1_pia_uart_bridge

Serial-terminal front end for the Apple-1 WozMon/PIA core. Converts an 8N1 UART receive stream into the PIA keyboard handshake (`kbd_rdy`/`kbd_ack`/`kbd_data`), and converts the PIA display handshake (`dsp_rdy`/`dsp_ack`/`dsp_data`) into an 8N1 UART transmit stream. It sits between the board UART pins and the PIA ports, and replaces the SystemC terminal model used during co-simulation.

## Interface
- `CLKS_PER_BIT`, 1042: clocks per UART bit; 10 MHz clock at 9600 baud. Must be ≥ 4.
- `FIFO_DEPTH`, 4: receive FIFO entries. Must be a power of 2, ≥ 2.
- `clk` in 1: single clock for all logic.
- `reset` in 1: asynchronous, active-low. 0 = reset.
- `uart_rxd` in 1: serial input, idle high, asynchronous to `clk`.
- `uart_txd` out 1: serial output, idle high.
- `kbd_rdy` out 1: key character available to the PIA.
- `kbd_data` out 7: ASCII key code.
- `kbd_ack` in 1: PIA has taken the key.
- `dsp_rdy` in 1: PIA has a display character.
- `dsp_data` in 7: ASCII display code.
- `dsp_ack` out 1: bridge has taken the display character.
- `rx_overrun` out 1: one-cycle pulse when a received byte is dropped.

## Operation
- **RX sync:** `uart_rxd` passes through a 2-flop synchronizer. The synchronizer resets to 1.
- **RX FSM (R_IDLE, R_START, R_DATA, R_STOP):**
  - A falling edge in R_IDLE moves to R_START.
  - R_START samples at the half-bit point. If the line is high, it is a false start and the FSM returns to R_IDLE.
  - R_DATA samples 8 bits, LSB first, one per `CLKS_PER_BIT`.
  - R_STOP samples the stop bit. If it is 0 (framing error), the byte is discarded.
- **RX filter on a good byte:**
  - Bit 7 is cleared.
  - 0x61–0x7A (a–z) are converted to 0x41–0x5A.
  - 0x0A (LF) is discarded.
  - All other bytes are pushed into the FIFO.
- **RX FIFO full:** the new byte is dropped and `rx_overrun` pulses for 1 cycle. FIFO contents are unchanged.
- **KBD FSM (K_IDLE, K_RDY, K_WAIT):** four-phase handshake.
  - K_IDLE: if the FIFO is not empty, load `kbd_data` from the FIFO head, set `kbd_rdy`=1, go to K_RDY.
  - K_RDY: hold `kbd_data` stable. When `kbd_ack`=1, clear `kbd_rdy`, pop the FIFO, go to K_WAIT.
  - K_WAIT: when `kbd_ack`=0, go to K_IDLE.
- **DSP capture:** when the TX path is idle, no LF is pending, `dsp_ack`=0 and `dsp_rdy`=1:
  - latch `dsp_data` into the TX shift register with bit 7 = 0;
  - set `dsp_ack`=1.
  - `dsp_ack` stays 1 until `dsp_rdy`=0 is sampled, then clears.
- **TX FSM (T_IDLE, T_START, T_DATA, T_STOP):** 1 start bit, 8 data bits LSB first, 1 stop bit, each `CLKS_PER_BIT` long.
- **CR expansion:** if the captured character is 0x0D, a pending-LF flag is set. After the CR stop bit completes, 0x0A is sent automatically. No new capture happens until the LF frame completes.

## Timing
- **Reset values:** `uart_txd`=1, `kbd_rdy`=0, `kbd_data`=0, `dsp_ack`=0, `rx_overrun`=0. All FSMs return to idle, the FIFO is emptied, and the pending-LF flag is cleared.
- **Reset mid-frame:** the frame is aborted and `uart_txd` returns high asynchronously.
- **RX latency:** the FIFO push happens 1 cycle after the stop-bit sample. `kbd_rdy` rises 1 cycle after that, provided the KBD FSM is in K_IDLE.
- **RX sample points:** about 2 synchronizer cycles + `CLKS_PER_BIT`/2 after the true start edge, then every `CLKS_PER_BIT`.
- **DSP capture latency:** `dsp_ack` rises 1 cycle after `dsp_rdy` is sampled high. `uart_txd` falls (start bit) in that same cycle.
- **TX frame length:** exactly 10·`CLKS_PER_BIT` clocks; 20·`CLKS_PER_BIT` for CR+LF.
- **Simultaneous push and pop** on a full FIFO: the pop happens first, so the push succeeds and there is no overrun.
- **Re-assertion limits:**
  - `kbd_rdy` never re-asserts while `kbd_ack`=1.
  - A held `dsp_rdy` never causes a second capture.

## Structure
- Package `apple_1_pia_uart_pkg` holds:
  - `ASCII_CR`=7'h0D, `ASCII_LF`=7'h0A, the lowercase bounds;
  - the `rx_state_t`, `kbd_state_t` and `tx_state_t` enums.
- Sub-module `apple_1_uart_rx`: synchronizer, RX FSM and baud counter. It outputs a byte plus a one-cycle valid strobe.
- The top level contains the filter, FIFO, KBD FSM, DSP capture and TX FSM.

## Test plan
All scenarios use `CLKS_PER_BIT`=16.
- **RX "a":** send 0x61, hold `kbd_ack`=0 → `kbd_rdy`=1 with `kbd_data`=0x41. Pulse `kbd_ack` → `kbd_rdy`=0 next cycle; it does not re-assert while `kbd_ack` is high.
- **Overrun and filtering:**
  - send 5 bytes 0x31–0x35 with no ack → `rx_overrun` pulses once; acks then deliver 0x31–0x34 in order;
  - send LF → nothing delivered.
- **Framing and false start:**
  - a stop bit of 0 → byte discarded, no `kbd_rdy`;
  - an 8-clock low glitch → RX FSM returns to idle, no byte.
- **DSP "R":** `dsp_rdy`=1 with `dsp_data`=0x52 → `dsp_ack`=1 next cycle; `uart_txd` carries the frame 0,0,1,0,0,1,0,1,0,1 over 160 clocks. `dsp_ack`=0 one cycle after `dsp_rdy` falls.
- **CR expansion:** `dsp_data`=0x0D → frames 0x0D then 0x0A back-to-back (320 clocks). A second `dsp_rdy` during that time is not acked until the LF stop bit ends.
- **Reset mid-frame:** assert `reset`=0 halfway through TX and RX frames → `uart_txd`=1 immediately, `kbd_rdy`=0, FIFO empty. A clean frame after release is received correctly.
